cut_sweep_checker: RTL and testbench

CUT_SWEEP_CHECKER -- requirements
Module: cut_sweep_checker

---
 rtl/cut_sweep_checker.sv | 134 +++++++++++++
 tb/tb_cut_sweep_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cut_sweep_checker.sv
// Exhaustive 4-input sweep checker: drives vectors 0..15 onto a/b/c/d, samples the
// circuit response f after a settle delay, and compares it against a golden truth table.
module cut_sweep_checker #(
  parameter logic [15:0] GOLDEN = 16'h77FF,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        fail_seen,
  output logic [15:0] resp_map,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Handshake: start is a single-cycle request honoured only in IDLE with abort low;
  // done is a single-cycle pulse on the edge that returns to IDLE after index 15,
  // and pass/err_count/first_fail/fail_seen/resp_map are valid from that cycle on.

  logic [1:0] state;
  logic [3:0] index;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic [4:0] err_next;

  assign mismatch = (f != GOLDEN[index]);

  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != 5'd16)) begin
      err_next = err_count + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      index      <= 4'd0;
      settle_cnt <= 4'd0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      fail_seen  <= 1'b0;
      resp_map   <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_HOLD;
            index      <= 4'd0;
            settle_cnt <= 4'd0;
            pass       <= 1'b0;
            err_count  <= 5'd0;
            first_fail <= 4'd0;
            fail_seen  <= 1'b0;
            resp_map   <= 16'd0;
          end
        end

        S_HOLD: begin
          if (abort) begin
            state      <= S_IDLE;
            index      <= 4'd0;
            settle_cnt <= 4'd0;
            pass       <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            state      <= S_IDLE;
            index      <= 4'd0;
            settle_cnt <= 4'd0;
            pass       <= 1'b0;
          end else begin
            resp_map[index] <= f;
            err_count       <= err_next;
            settle_cnt      <= 4'd0;
            if (mismatch && !fail_seen) begin
              first_fail <= index;
              fail_seen  <= 1'b1;
            end
            // Index returns to 0 on completion so the stimulus lines idle low.
            if (index == 4'd15) begin
              state <= S_IDLE;
              index <= 4'd0;
              done  <= 1'b1;
              pass  <= (err_next == 5'd0);
            end else begin
              state <= S_HOLD;
              index <= index + 4'd1;
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          index      <= 4'd0;
          settle_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign a         = index[0];
  assign b         = index[1];
  assign c         = index[2];
  assign d         = index[3];
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_cut_sweep_checker.sv
// Directed bench for cut_sweep_checker: clean, stuck-at, abort, restart-while-busy and
// mid-sweep reset scenarios, with sweep results checked through an expected-result queue.
module tb_cut_sweep_checker;

  localparam int W = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        f;
  logic        a, b, c, d;
  logic        busy, done, pass, fail_seen;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [15:0] resp_map;
  logic [1:0]  fsm_state;

  int f_mode = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int done_seen;
  logic [W-1:0] exp_q[$];

  cut_sweep_checker #(.GOLDEN(16'h77FF), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_seen(fail_seen),
    .resp_map(resp_map), .fsm_state(fsm_state)
  );

  // Circuit under test: f = NOT(a AND b AND d), or stuck at 1 / 0.
  always_comb begin
    case (f_mode)
      0:       f = !(a && b && d);
      1:       f = 1'b1;
      default: f = 1'b0;
    endcase
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int mode);
    logic [15:0] gold;
    logic [15:0] resp;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        fs;
    logic        fv;
    logic [3:0]  idx;
    gold  = 16'h77FF;
    resp  = 16'd0;
    err   = 5'd0;
    first = 4'd0;
    fs    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = i[3:0];
      if (mode == 0) fv = !(idx[0] && idx[1] && idx[3]);
      else           fv = (mode == 1);
      resp[i] = fv;
      if (fv != gold[i]) begin
        err = err + 5'd1;
        if (!fs) begin
          first = idx;
          fs    = 1'b1;
        end
      end
    end
    exp_q.push_back({(err == 5'd0), fs, first, err, resp});
  endtask

  task automatic run_sweep(input int mode, input int restart_idx);
    int         lat;
    logic       seq_ok;
    logic [W-1:0] e;
    f_mode = mode;
    push_expected(mode);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 1);
    check("vec_at_start", {28'd0, d, c, b, a}, 0);
    lat    = 0;
    seq_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      start = (restart_idx >= 0) && (n == 2 * restart_idx + 1);
      tick();
      if (n < 32 && ({d, c, b, a} !== 4'(n / 2) || busy !== 1'b1)) seq_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", lat, 32);
    check("vec_sequence", {31'd0, seq_ok}, 1);
    if (lat != 0) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("result_word", {5'd0, pass, fail_seen, first_fail, err_count, resp_map}, {5'd0, e});
      end
      check("idle_at_done", {27'd0, busy, d, c, b, a}, 0);
      tick();
      check("done_one_cycle", {31'd0, done}, 0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    #2;
    check("reset_flags", {22'd0, fsm_state, busy, done, pass, fail_seen, d, c, b, a}, 0);
    check("reset_err", {27'd0, err_count}, 0);
    check("reset_first", {28'd0, first_fail}, 0);
    check("reset_resp", {16'd0, resp_map}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    run_sweep(0, -1);
    check("good_pass", {31'd0, pass}, 1);
    check("good_err", {27'd0, err_count}, 0);
    check("good_resp", {16'd0, resp_map}, 32'h77FF);
    check("good_fail_seen", {31'd0, fail_seen}, 0);

    run_sweep(1, -1);
    check("one_err", {27'd0, err_count}, 2);
    check("one_first", {28'd0, first_fail}, 11);
    check("one_fail_seen", {31'd0, fail_seen}, 1);
    check("one_pass", {31'd0, pass}, 0);
    check("one_resp", {16'd0, resp_map}, 32'hFFFF);

    run_sweep(2, -1);
    check("zero_err", {27'd0, err_count}, 14);
    check("zero_first", {28'd0, first_fail}, 0);
    check("zero_resp", {16'd0, resp_map}, 0);

    run_sweep(0, 3);
    check("restart_pass", {31'd0, pass}, 1);

    f_mode = 0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_vec_before", {28'd0, d, c, b, a}, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {27'd0, busy, done, pass, fail_seen, d, c, b, a} & 32'h1FE, 0);
    check("abort_vec", {28'd0, d, c, b, a}, 0);
    check("abort_partial_resp", {16'd0, resp_map}, 32'h001F);
    check("abort_partial_err", {27'd0, err_count}, 0);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_sweep(0, -1);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", {31'd0, busy}, 0);
    check("results_held", {16'd0, resp_map}, 32'h77FF);

    f_mode = 1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    check("reset_vec_before", {28'd0, d, c, b, a}, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_flags", {22'd0, fsm_state, busy, done, pass, fail_seen, d, c, b, a}, 0);
    check("midreset_err", {27'd0, err_count}, 0);
    check("midreset_first", {28'd0, first_fail}, 0);
    check("midreset_resp", {16'd0, resp_map}, 0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("reset_no_done", done_seen, 0);
    run_sweep(1, -1);
    check("post_reset_err", {27'd0, err_count}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
